// File: rtl/rho_pkg.sv
// rtl/rho_pkg.sv - shared sizes, FSM encoding and rho offset table
package rho_pkg;

  localparam int PAGE_W = 25;
  localparam int NPAGES = 64;
  localparam int IDX_W  = 6;

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  typedef logic [PAGE_W-1:0] page_t;
  typedef logic [IDX_W-1:0]  idx_t;

  // Keccak rho rotation amount for lane (x,y), lane length 64
  function automatic idx_t rho_off(input int x, input int y);
    case (5 * x + y)
      0:  return 6'd0;
      1:  return 6'd36;
      2:  return 6'd3;
      3:  return 6'd41;
      4:  return 6'd18;
      5:  return 6'd1;
      6:  return 6'd44;
      7:  return 6'd10;
      8:  return 6'd45;
      9:  return 6'd2;
      10: return 6'd62;
      11: return 6'd6;
      12: return 6'd43;
      13: return 6'd15;
      14: return 6'd61;
      15: return 6'd28;
      16: return 6'd55;
      17: return 6'd25;
      18: return 6'd21;
      19: return 6'd56;
      20: return 6'd27;
      21: return 6'd20;
      22: return 6'd39;
      23: return 6'd8;
      24: return 6'd14;
      default: return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/rho_lane_select.sv
// rtl/rho_lane_select.sv - picks bit (z - off) mod 64 from one lane column
module rho_lane_select
  import rho_pkg::*;
(
  input  logic [NPAGES-1:0] lane_col,
  input  logic [IDX_W-1:0]  z,
  input  logic [IDX_W-1:0]  off,
  output logic              bit_out
);

  logic [IDX_W-1:0] src_idx;

  // 6-bit subtraction wraps naturally, giving the mod-64 source slice
  assign src_idx = z - off;
  assign bit_out = lane_col[src_idx];

endmodule

// File: rtl/rho_rotate.sv
// rtl/rho_rotate.sv - buffers 64 slice-pages and re-emits them rho-rotated
module rho_rotate
  import rho_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [PAGE_W-1:0] in_data,
  output logic              Ready,
  output logic [PAGE_W-1:0] Out,
  output logic              Done,
  output logic [IDX_W-1:0]  out_index
);

  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  wcnt_q, wcnt_d;
  logic [IDX_W-1:0]  rcnt_q, rcnt_d;
  logic              phase_q, phase_d;
  logic [PAGE_W-1:0] out_q, out_d;
  logic              done_q, done_d;
  logic [IDX_W-1:0]  out_index_q, out_index_d;
  logic              mem_we;

  logic [PAGE_W-1:0] page_mem_q [NPAGES];
  logic [NPAGES-1:0] lane_col [PAGE_W];
  logic [PAGE_W-1:0] rot_page;

  always_comb begin
    for (int l = 0; l < PAGE_W; l++) begin
      for (int z = 0; z < NPAGES; z++) begin
        lane_col[l][z] = page_mem_q[z][l];
      end
    end
  end

  for (genvar l = 0; l < PAGE_W; l++) begin : g_lane
    localparam idx_t OFF = rho_off(l % 5, l / 5);
    rho_lane_select u_sel (
      .lane_col (lane_col[l]),
      .z        (rcnt_q),
      .off      (OFF),
      .bit_out  (rot_page[l])
    );
  end

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    phase_d     = phase_q;
    out_d       = out_q;
    done_d      = 1'b0;
    out_index_d = out_index_q;
    mem_we      = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          mem_we = 1'b1;
          wcnt_d = wcnt_q + 6'd1;
          if (wcnt_q == IDX_W'(NPAGES - 1)) begin
            state_d = ST_EMIT;
            wcnt_d  = '0;
            rcnt_d  = '0;
            phase_d = 1'b0;
          end
        end
      end
      default: begin
        if (!phase_q) begin
          done_d      = 1'b1;
          out_d       = rot_page;
          out_index_d = rcnt_q;
          rcnt_d      = rcnt_q + 6'd1;
          phase_d     = 1'b1;
        end else begin
          phase_d = 1'b0;
          // rcnt wrapped to 0 after page 63: this gap edge closes EMIT
          if (rcnt_q == '0) begin
            state_d = ST_LOAD;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      phase_q     <= 1'b0;
      out_q       <= '0;
      done_q      <= 1'b0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      phase_q     <= phase_d;
      out_q       <= out_d;
      done_q      <= done_d;
      out_index_q <= out_index_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      page_mem_q[wcnt_q] <= in_data;
    end
  end

  assign Ready     = (state_q == ST_LOAD);
  assign Out       = out_q;
  assign Done      = done_q;
  assign out_index = out_index_q;

endmodule

// File: tb/tb_rho_rotate.sv
// tb/tb_rho_rotate.sv - scoreboard bench for rho_rotate against a lane-rotation model
module tb_rho_rotate;

  typedef struct {
    logic [5:0]  idx;
    logic [24:0] page;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [24:0] in_data;
  logic        Ready;
  logic [24:0] Out;
  logic        Done;
  logic [5:0]  out_index;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_done = 0;
  int   pops = 0;

  int R[5][5] = '{
    '{0, 36, 3, 41, 18},
    '{1, 44, 10, 45, 2},
    '{62, 6, 43, 15, 61},
    '{28, 55, 25, 21, 56},
    '{27, 20, 39, 8, 14}
  };

  rho_rotate dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .Ready     (Ready),
    .Out       (Out),
    .Done      (Done),
    .out_index (out_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Model: each lane is a 64-bit word rotated left by its offset
  function automatic void push_model(input logic [24:0] pg [64]);
    logic [63:0] lane, rot;
    logic [24:0] outp [64];
    exp_t e;
    for (int z = 0; z < 64; z++) outp[z] = '0;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        int b = 5 * y + x;
        int r = R[x][y];
        for (int z = 0; z < 64; z++) lane[z] = pg[z][b];
        rot = (r == 0) ? lane : ((lane << r) | (lane >> (64 - r)));
        for (int z = 0; z < 64; z++) outp[z][b] = rot[z];
      end
    end
    for (int z = 0; z < 64; z++) begin
      e.idx  = 6'(z);
      e.page = outp[z];
      exp_q.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (Done) begin
      pops++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got index %0d expected no output", out_index);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_index", 32'(out_index), 32'(e.idx));
        check("out_page", 32'(Out), 32'(e.page));
        if (out_index != 6'd0) check("done_spacing", 32'(cyc - last_done), 32'd2);
      end
      last_done = cyc;
    end
  end

  task automatic load(input logic [24:0] pg [64], input bit gaps);
    pops = 0;
    push_model(pg);
    for (int z = 0; z < 64; z++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = pg[z];
      @(posedge clk);
      #1;
      check("ready_load", 32'(Ready), (z == 63) ? 32'd0 : 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_ready(input bit noise);
    int c;
    for (c = 1; c <= 200; c++) begin
      in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data  = 25'($urandom);
      @(posedge clk);
      #1;
      if (Ready) break;
    end
    in_valid = 1'b0;
    check("ready_latency", 32'(c), 32'd128);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(pops), 32'd64);
  endtask

  task automatic rand_pages(output logic [24:0] pg [64]);
    for (int z = 0; z < 64; z++) pg[z] = 25'($urandom);
  endtask

  logic [24:0] pages [64];

  initial begin
    int c;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", 32'(Out), 32'd0);
    check("reset_done", 32'(Done), 32'd0);
    check("reset_ready", 32'(Ready), 32'd1);
    check("reset_index", 32'(out_index), 32'd0);
    reset = 1'b0;

    foreach (pages[z]) pages[z] = '0;
    pages[0] = 25'h0000002;
    load(pages, 1'b0);
    wait_ready(1'b0);

    foreach (pages[z]) pages[z] = '0;
    pages[3] = 25'h0000004;
    load(pages, 1'b0);
    wait_ready(1'b0);

    foreach (pages[z]) pages[z] = '0;
    pages[5] = 25'h0000001;
    load(pages, 1'b0);
    wait_ready(1'b0);

    // Pages offered during EMIT must be dropped
    rand_pages(pages);
    load(pages, 1'b0);
    wait_ready(1'b1);

    rand_pages(pages);
    load(pages, 1'b0);
    for (c = 0; c < 300; c++) begin
      @(negedge clk);
      if (Done && out_index == 6'd10) break;
    end
    check("reach_page10", 32'(c < 300), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midreset_done", 32'(Done), 32'd0);
    check("midreset_ready", 32'(Ready), 32'd1);
    check("midreset_out", 32'(Out), 32'd0);
    exp_q.delete();
    rand_pages(pages);
    load(pages, 1'b0);
    wait_ready(1'b0);

    for (int n = 0; n < 3; n++) begin
      rand_pages(pages);
      load(pages, 1'b1);
      wait_ready(1'b1);
    end

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
